// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle between the AHB masters, the round-robin arbiter and the bridge slave port.
// The arbiter connects through the slave modport; the master-side driver uses the master modport.
interface ahb_master_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4
);
    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0]    hbusreq;
    logic [NUM_MASTERS-1:0]    hlock;
    logic [32*NUM_MASTERS-1:0] haddr_m;
    logic [2*NUM_MASTERS-1:0]  htrans_m;
    logic [NUM_MASTERS-1:0]    hwrite_m;
    logic [32*NUM_MASTERS-1:0] hwdata_m;
    logic                      hready;

    logic [NUM_MASTERS-1:0]    hgrant;
    logic [MW-1:0]             hmaster;
    logic                      hmastlock;
    logic [31:0]               haddr;
    logic [1:0]                htrans;
    logic                      hwrite;
    logic [31:0]               hwdata;

    modport slave (
        input  hbusreq, hlock, haddr_m, htrans_m, hwrite_m, hwdata_m, hready,
        output hgrant, hmaster, hmastlock, haddr, htrans, hwrite, hwdata
    );

    modport master (
        output hbusreq, hlock, haddr_m, htrans_m, hwrite_m, hwdata_m, hready,
        input  hgrant, hmaster, hmastlock, haddr, htrans, hwrite, hwdata
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing the bridge's AHB slave port between NUM_MASTERS masters.
// Grants one owner per address phase, muxes its address-phase signals and the data-phase owner's hwdata.
module ahb_master_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 8
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_master_arbiter_if.slave bus
);
    localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {PARK, OWN} state_t;

    state_t                 state, state_nxt;
    logic [MW-1:0]          owner, owner_nxt;
    logic [MW-1:0]          owner_data, owner_data_nxt;
    logic [CW-1:0]          hold_cnt, hold_cnt_nxt;
    logic                   mastlock, mastlock_nxt;

    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   others_req;
    logic                   keep;
    logic                   rr_found;
    logic [MW-1:0]          rr_idx;
    logic [MW-1:0]          rr_winner;
    logic [1:0]             htrans_sel;
    logic [1:0]             htrans_c;
    logic                   grant_new;

    assign owner_oh   = NUM_MASTERS'(1) << owner;
    assign others_req = |(bus.hbusreq & ~owner_oh);
    assign keep       = bus.hbusreq[owner] | bus.hlock[owner];

    // Search from owner+1 upward with wrap; the owner itself wins only as sole requester.
    always_comb begin
        rr_found  = 1'b0;
        rr_idx    = owner;
        rr_winner = owner;
        for (int unsigned k = 1; k < NUM_MASTERS; k++) begin
            rr_idx = MW'((32'(owner) + k) % NUM_MASTERS);
            if (!rr_found && bus.hbusreq[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    // State register; everything freezes while the bridge stretches a phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state      <= PARK;
            owner      <= DEF_IDX;
            owner_data <= DEF_IDX;
            hold_cnt   <= '0;
            mastlock   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            owner_data <= owner_data_nxt;
            hold_cnt   <= hold_cnt_nxt;
            mastlock   <= mastlock_nxt;
        end
    end

    // Next-state and arbitration decision.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        owner_data_nxt = owner_data;
        hold_cnt_nxt   = hold_cnt;
        mastlock_nxt   = mastlock;
        grant_new      = 1'b0;
        if (bus.hready) begin
            owner_data_nxt = owner;
            if (htrans_c[1] && (hold_cnt != CNT_MAX)) begin
                hold_cnt_nxt = hold_cnt + CW'(1);
            end
            unique case (state)
                PARK: begin
                    if (|bus.hbusreq) begin
                        state_nxt = OWN;
                        grant_new = 1'b1;
                    end
                end
                OWN: begin
                    if (!keep) begin
                        if (others_req) begin
                            grant_new = 1'b1;
                        end else begin
                            state_nxt    = PARK;
                            owner_nxt    = DEF_IDX;
                            mastlock_nxt = 1'b0;
                            hold_cnt_nxt = '0;
                        end
                    end else if ((hold_cnt == CNT_MAX) && !bus.hlock[owner] && others_req) begin
                        grant_new = 1'b1;
                    end
                end
                default: state_nxt = PARK;
            endcase
            if (grant_new) begin
                owner_nxt    = rr_winner;
                mastlock_nxt = bus.hlock[rr_winner];
                hold_cnt_nxt = '0;
            end
        end
    end

    // Output mux: address phase from the owner, write data from the data-phase owner.
    always_comb begin
        bus.haddr  = '0;
        bus.hwrite = 1'b0;
        bus.hwdata = '0;
        htrans_sel = 2'b00;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (owner == MW'(i)) begin
                bus.haddr  = bus.haddr_m[32*i +: 32];
                htrans_sel = bus.htrans_m[2*i +: 2];
                bus.hwrite = bus.hwrite_m[i];
            end
            if (owner_data == MW'(i)) begin
                bus.hwdata = bus.hwdata_m[32*i +: 32];
            end
        end
        htrans_c      = (state == PARK) ? 2'b00 : htrans_sel;
        bus.htrans    = htrans_c;
        bus.hgrant    = owner_oh;
        bus.hmaster   = owner;
        bus.hmastlock = mastlock;
    end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed self-checking bench for ahb_master_arbiter (4 masters, default 0, hold limit 8).
module tb_ahb_master_arbiter;
    localparam int unsigned NM = 4;

    logic        hclk = 1'b0;
    logic        hresetn;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned exp_own;

    ahb_master_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    ahb_master_arbiter #(
        .NUM_MASTERS   (NM),
        .DEFAULT_MASTER(0),
        .MAX_HOLD      (8)
    ) dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input int unsigned m, input logic req, input logic lock,
                         input logic [1:0] trans, input logic [31:0] addr,
                         input logic write, input logic [31:0] data);
        bus.hbusreq[m]          = req;
        bus.hlock[m]            = lock;
        bus.htrans_m[2*m +: 2]  = trans;
        bus.haddr_m[32*m +: 32] = addr;
        bus.hwrite_m[m]         = write;
        bus.hwdata_m[32*m +: 32] = data;
    endtask

    initial begin
        hresetn      = 1'b1;
        bus.hbusreq  = '0;
        bus.hlock    = '0;
        bus.haddr_m  = '0;
        bus.htrans_m = '0;
        bus.hwrite_m = '0;
        bus.hwdata_m = '0;
        bus.hready   = 1'b1;
        #1 hresetn = 1'b0;
        for (int unsigned m = 0; m < NM; m++) drive(m, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'hD000_0000 + m);
        #10;
        check("rst_hgrant", 32'(bus.hgrant), 32'h1);
        check("rst_hmaster", 32'(bus.hmaster), 32'h0);
        check("rst_hmastlock", 32'(bus.hmastlock), 32'h0);
        check("rst_htrans", 32'(bus.htrans), 32'h0);
        check("rst_hold_cnt", 32'(dut.hold_cnt), 32'h0);
        hresetn = 1'b1;

        // Parked: default master drives NONSEQ but the bridge must only see IDLE.
        drive(0, 1'b0, 1'b0, 2'b10, 32'h100, 1'b0, 32'hD000_0000);
        for (int i = 0; i < 10; i++) begin
            step();
            check("park_hgrant", 32'(bus.hgrant), 32'h1);
            check("park_hmaster", 32'(bus.hmaster), 32'h0);
            check("park_htrans", 32'(bus.htrans), 32'h0);
        end
        check("park_hold_cnt", 32'(dut.hold_cnt), 32'h0);

        // Single write from M2.
        drive(0, 1'b0, 1'b0, 2'b00, 32'h100, 1'b0, 32'hD000_0000);
        drive(2, 1'b1, 1'b0, 2'b10, 32'h0000_0010, 1'b1, 32'hA5A5_0001);
        step();
        check("m2_hgrant", 32'(bus.hgrant), 32'h4);
        check("m2_hmaster", 32'(bus.hmaster), 32'h2);
        check("m2_haddr", bus.haddr, 32'h0000_0010);
        check("m2_htrans", 32'(bus.htrans), 32'h2);
        check("m2_hwrite", 32'(bus.hwrite), 32'h1);
        bus.hbusreq[2] = 1'b0;
        step();
        bus.htrans_m[5:4] = 2'b00;
        #1;
        check("m2_hwdata", bus.hwdata, 32'hA5A5_0001);
        check("m2_park_hgrant", 32'(bus.hgrant), 32'h1);
        check("m2_park_htrans", 32'(bus.htrans), 32'h0);
        step();
        check("m2_after_hwdata", bus.hwdata, 32'hD000_0000);

        // All four request unlocked SEQ bursts: rotation 1,2,3,0 every 8 phases.
        for (int unsigned m = 0; m < NM; m++) drive(m, 1'b1, 1'b0, 2'b11, 32'h1000 * m, 1'b0, 32'hD000_0000 + m);
        for (int unsigned k = 1; k <= 40; k++) begin
            step();
            exp_own = ((k - 1) / 8 + 1) % NM;
            check("rr_hmaster", 32'(bus.hmaster), exp_own);
            check("rr_hgrant", 32'(bus.hgrant), 32'(1) << exp_own);
        end
        check("rr_hmastlock", 32'(bus.hmastlock), 32'h0);
        bus.hbusreq  = '0;
        bus.htrans_m = '0;
        step();
        check("rr_park_hgrant", 32'(bus.hgrant), 32'h1);
        check("rr_park_htrans", 32'(bus.htrans), 32'h0);

        // Locked 12-beat burst from M1 while M3 waits.
        drive(3, 1'b1, 1'b0, 2'b10, 32'h3000, 1'b0, 32'hD000_0003);
        drive(1, 1'b1, 1'b1, 2'b10, 32'h2000, 1'b1, 32'hD000_0001);
        step();
        for (int b = 1; b <= 12; b++) begin
            check("lock_hmaster", 32'(bus.hmaster), 32'h1);
            check("lock_hmastlock", 32'(bus.hmastlock), 32'h1);
            if (b == 12) begin
                bus.hbusreq[1] = 1'b0;
                bus.hlock[1]   = 1'b0;
            end else begin
                bus.htrans_m[3:2] = 2'b11;
            end
            step();
        end
        check("unlock_hgrant", 32'(bus.hgrant), 32'h8);
        check("unlock_hmaster", 32'(bus.hmaster), 32'h3);
        check("unlock_hmastlock", 32'(bus.hmastlock), 32'h0);
        bus.hbusreq  = '0;
        bus.htrans_m = '0;
        step();
        check("lock_park_hgrant", 32'(bus.hgrant), 32'h1);

        // Bridge wait states during M0 ownership with M2 pending.
        drive(0, 1'b1, 1'b0, 2'b10, 32'h40, 1'b1, 32'h1111_0000);
        drive(2, 1'b0, 1'b0, 2'b10, 32'h50, 1'b1, 32'h2222_0000);
        step();
        check("wait_own_hgrant", 32'(bus.hgrant), 32'h1);
        check("wait_own_htrans", 32'(bus.htrans), 32'h2);
        step();
        bus.hready     = 1'b0;
        bus.hbusreq[0] = 1'b0;
        bus.hbusreq[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_hgrant", 32'(bus.hgrant), 32'h1);
            check("wait_hmaster", 32'(bus.hmaster), 32'h0);
            check("wait_hwdata", bus.hwdata, 32'h1111_0000);
        end
        bus.hready = 1'b1;
        step();
        check("wait_done_hgrant", 32'(bus.hgrant), 32'h4);
        check("wait_done_hmaster", 32'(bus.hmaster), 32'h2);
        check("wait_done_hwdata", bus.hwdata, 32'h1111_0000);
        step();
        check("wait_m2_hwdata", bus.hwdata, 32'h2222_0000);

        // Asynchronous reset in the middle of an M3 burst.
        bus.hbusreq[2] = 1'b0;
        drive(3, 1'b1, 1'b0, 2'b11, 32'h3100, 1'b0, 32'hD000_0003);
        step();
        check("m3_hmaster", 32'(bus.hmaster), 32'h3);
        for (int i = 0; i < 3; i++) step();
        check("m3_hold_cnt", 32'(dut.hold_cnt), 32'h3);
        #3 hresetn = 1'b0;
        #1;
        check("arst_hgrant", 32'(bus.hgrant), 32'h1);
        check("arst_htrans", 32'(bus.htrans), 32'h0);
        check("arst_hold_cnt", 32'(dut.hold_cnt), 32'h0);
        check("arst_hmaster", 32'(bus.hmaster), 32'h0);
        check("arst_hmastlock", 32'(bus.hmastlock), 32'h0);
        #3 hresetn = 1'b1;
        bus.hbusreq = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
